// File: rtl/cic_pkg.sv
// Shared constants and state encoding for the CIC decimator timing controller.
package cic_pkg;

    localparam int unsigned DEF_CHANNELS   = 8;
    localparam int unsigned DEF_PDM_DIV    = 50;
    localparam int unsigned DEF_DECIMATION = 64;
    localparam int unsigned MIN_DECIMATION = 2;

    // One integrator/comb sweep over all channels needs this many sys clk cycles.
    localparam int unsigned SWEEP_CYCLES   = 2 * DEF_CHANNELS + 2;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned sweep_cycles(input int unsigned channels);
        return 2 * channels + 2;
    endfunction

endpackage

// File: rtl/cic_pdm_clkgen.sv
// PDM clock divider: counts 0..div-1, produces a registered pdm_clk and the
// read strobe on the last count of each period. A new divisor is adopted only
// at a period wrap (or while loading in idle), so no phase is ever shortened.
module cic_pdm_clkgen #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned RST_DIV   = 50
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load_i,
    input  logic                 run_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 pdm_clk_o,
    output logic                 read_en_o
);

    localparam logic [DIV_WIDTH-1:0] One    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] RstDiv = DIV_WIDTH'(RST_DIV);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
    logic                 pdm_clk_q, pdm_clk_d;
    logic                 read_en_q, read_en_d;
    logic                 wrap;

    assign wrap = (div_cnt_q == cur_div_q - One);

    // Next count/divisor; outputs are decoded from next-state so they align with div_cnt.
    always_comb begin
        div_cnt_d = div_cnt_q + One;
        cur_div_d = cur_div_q;
        if (load_i || !run_i || wrap) begin
            div_cnt_d = '0;
        end
        if (load_i || wrap) begin
            cur_div_d = div_i;
        end
        pdm_clk_d = run_i && (div_cnt_d >= (cur_div_d >> 1));
        read_en_d = run_i && (div_cnt_d == cur_div_d - One);
    end

    // Divider state and registered outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            div_cnt_q <= '0;
            cur_div_q <= RstDiv;
            pdm_clk_q <= 1'b0;
            read_en_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cur_div_q <= cur_div_d;
            pdm_clk_q <= pdm_clk_d;
            read_en_q <= read_en_d;
        end
    end

    assign pdm_clk_o = pdm_clk_q;
    assign read_en_o = read_en_q;

endmodule

// File: rtl/cic_timing_ctrl.sv
// Timing sequencer for the multichannel PDM CIC decimator: run/idle FSM,
// decimation counter, sweep enables and frame-synchronous config update.
module cic_timing_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned CHANNELS       = DEF_CHANNELS,
    parameter int unsigned DIV_WIDTH      = 8,
    parameter int unsigned DEC_WIDTH      = 10,
    parameter int unsigned RST_PDM_DIV    = DEF_PDM_DIV,
    parameter int unsigned RST_DECIMATION = DEF_DECIMATION
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] cfg_pdm_div,
    input  logic [DEC_WIDTH-1:0] cfg_decimation,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 pdm_clk,
    output logic                 pdm_read_enable,
    output logic                 integrator_enable,
    output logic                 comb_enable,
    output logic                 frame_start,
    output logic                 running
);

    localparam logic [DIV_WIDTH-1:0] MinDiv = DIV_WIDTH'(sweep_cycles(CHANNELS));
    localparam logic [DEC_WIDTH-1:0] MinDec = DEC_WIDTH'(MIN_DECIMATION);
    localparam logic [DIV_WIDTH-1:0] RstDiv = DIV_WIDTH'(RST_PDM_DIV);
    localparam logic [DEC_WIDTH-1:0] RstDec = DEC_WIDTH'(RST_DECIMATION);
    localparam logic [DEC_WIDTH-1:0] DecOne = DEC_WIDTH'(1);

    state_e               state_q, state_d;
    logic [DEC_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic [DIV_WIDTH-1:0] act_div_q, act_div_d, shd_div_q, shd_div_d;
    logic [DEC_WIDTH-1:0] act_dec_q, act_dec_d, shd_dec_q, shd_dec_d;
    logic                 pending_q, pending_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 integ_q, integ_d;
    logic                 comb_q, comb_d;
    logic                 run_next, leaving_run, read_en;
    logic                 cfg_hs, cfg_legal, dec_last, frame_end;

    assign run_next    = (state_d == StRun);
    assign leaving_run = (state_q == StRun) && !enable;
    assign dec_last    = (dec_cnt_q == act_dec_q - DecOne);
    assign frame_end   = integ_q && dec_last;
    assign cfg_hs      = cfg_valid && !pending_q;
    assign cfg_legal   = (cfg_pdm_div >= MinDiv) && (cfg_decimation >= MinDec);

    cic_pdm_clkgen #(
        .DIV_WIDTH (DIV_WIDTH),
        .RST_DIV   (RST_PDM_DIV)
    ) u_clkgen (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (state_q == StIdle),
        .run_i     (run_next),
        .div_i     (act_div_q),
        .pdm_clk_o (pdm_clk),
        .read_en_o (read_en)
    );

    // Run/idle FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sweep enables and decimation counter; everything clears when not running next cycle.
    always_comb begin
        integ_d   = run_next && read_en;
        comb_d    = comb_q;
        dec_cnt_d = dec_cnt_q;
        if (!run_next) begin
            comb_d    = 1'b0;
            dec_cnt_d = '0;
        end else begin
            // Decided one cycle early so comb_enable toggles together with integrator_enable.
            if (read_en) comb_d = dec_last;
            if (integ_q) dec_cnt_d = dec_last ? '0 : dec_cnt_q + DecOne;
        end
    end

    // Config handshake: direct apply when idle, shadow + frame-boundary apply when running.
    always_comb begin
        act_div_d = act_div_q;
        act_dec_d = act_dec_q;
        shd_div_d = shd_div_q;
        shd_dec_d = shd_dec_q;
        pending_d = pending_q;
        cfg_err_d = cfg_hs && !cfg_legal;
        if (pending_q && (frame_end || leaving_run)) begin
            act_div_d = shd_div_q;
            act_dec_d = shd_dec_q;
            pending_d = 1'b0;
        end
        // cfg_hs implies !pending_q, so this never collides with the shadow apply above.
        if (cfg_hs && cfg_legal) begin
            if (state_q == StIdle || leaving_run) begin
                act_div_d = cfg_pdm_div;
                act_dec_d = cfg_decimation;
            end else begin
                shd_div_d = cfg_pdm_div;
                shd_dec_d = cfg_decimation;
                pending_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= StIdle;
            dec_cnt_q <= '0;
            act_div_q <= RstDiv;
            act_dec_q <= RstDec;
            shd_div_q <= RstDiv;
            shd_dec_q <= RstDec;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
            integ_q   <= 1'b0;
            comb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_cnt_q <= dec_cnt_d;
            act_div_q <= act_div_d;
            act_dec_q <= act_dec_d;
            shd_div_q <= shd_div_d;
            shd_dec_q <= shd_dec_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
            integ_q   <= integ_d;
            comb_q    <= comb_d;
        end
    end

    assign cfg_ready         = !pending_q;
    assign cfg_err           = cfg_err_q;
    assign pdm_read_enable   = read_en;
    assign integrator_enable = integ_q;
    assign comb_enable       = comb_q;
    assign frame_start       = integ_q && (dec_cnt_q == '0);
    assign running           = (state_q == StRun);

endmodule

// File: doc/cic_timing_ctrl.md
Name: cic_timing_ctrl

Overview:
- Sequencer for the multichannel PDM CIC decimator datapath.
- Generates the microphone PDM clock.
- Issues the per-sample enables consumed by the CIC filter:
  - pdm_read_enable, which latches the PDM bits;
  - integrator_enable, which starts a channel sweep;
  - comb_enable, which marks the decimated sweep.
- Owns the runtime configuration (clock divider, decimation ratio) and applies it glitch-free on frame boundaries.

Parameters:
- CHANNELS, 8, number of PDM channels; sets the minimum sweep length.
- DIV_WIDTH, 8, width of the PDM clock divider.
- DEC_WIDTH, 10, width of the decimation ratio.
- RST_PDM_DIV, 50, divider value loaded at reset (sys clk cycles per PDM period).
- RST_DECIMATION, 64, decimation ratio loaded at reset.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- cfg_pdm_div  in  DIV_WIDTH  requested divider.
- cfg_decimation  in  DEC_WIDTH  requested decimation ratio.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_err  out  1  one-cycle pulse: illegal config rejected.
- pdm_clk  out  1  microphone clock.
- pdm_read_enable  out  1  one-cycle pulse: latch PDM bits.
- integrator_enable  out  1  one-cycle pulse: start integrator sweep.
- comb_enable  out  1  level, high during the decimated sweep.
- frame_start  out  1  one-cycle pulse at the first sample of each decimation frame.
- running  out  1  high in RUN.

Behaviour:
- Reset (asynchronous, resetn=1):
  - state=IDLE; div_cnt=0; dec_cnt=0; pending=0.
  - Active registers = RST_PDM_DIV / RST_DECIMATION.
  - All outputs 0, except cfg_ready=1.
- States:
  - IDLE -> RUN when enable=1; counters start at 0 on the next cycle.
  - RUN -> IDLE on the cycle enable=0. Counters clear and outputs drop to 0 in that same cycle, mid-period included. No partial pulses.
- Divider:
  - div_cnt counts 0..pdm_div-1, then wraps.
  - pdm_clk=0 while div_cnt < pdm_div>>1, else 1. Odd pdm_div gives the extra cycle to the high phase.
  - pdm_clk is registered (no combinational glitch).
- pdm_read_enable: pulses on the cycle div_cnt==pdm_div-1.
- integrator_enable: pulses exactly 1 cycle after pdm_read_enable, so the PDM register is stable.
- Decimation counter:
  - dec_cnt increments on each integrator_enable and wraps at decimation-1 -> 0.
  - frame_start pulses together with integrator_enable when dec_cnt==0, i.e. the pre-increment value.
- comb_enable:
  - Rises with the integrator_enable pulse that has dec_cnt==decimation-1.
  - Falls with the next integrator_enable pulse.
  - So it is high for exactly one PDM period in every `decimation` periods.
- Sweep budget: the datapath needs 2*CHANNELS+2 clk cycles per sweep. Legal pdm_div >= 2*CHANNELS+2 (18 at default). Legal decimation >= 2.
- Config handshake:
  - A transfer happens when cfg_valid & cfg_ready; cfg_ready = !pending.
  - An illegal value is not latched. cfg_err pulses 1 cycle after the handshake; pending stays 0.
  - In IDLE, a legal value is applied the next cycle and pending is not set.
  - In RUN, a legal value goes into shadow registers and sets pending=1. It is applied on the cycle dec_cnt wraps to 0 (frame boundary): the new pdm_div takes effect at the next div_cnt wrap, and dec_cnt restarts under the new ratio. pending then clears.
  - A handshake on the same cycle as a frame boundary is applied at the following boundary.
- Simultaneous events:
  - enable falling while pending=1: the shadow value is applied immediately on entering IDLE.
  - resetn dominates everything, and discards any pending value.

Decomposition:
- Package cic_pkg:
  - default divider and decimation constants;
  - the sweep-budget constant SWEEP_CYCLES = 2*CHANNELS+2;
  - state encoding (IDLE, RUN).
- Sub-module cic_pdm_clkgen: div_cnt, pdm_clk, pdm_read_enable. Inputs: load, div value, run.
- Decimation counter, config shadow logic and FSM stay at top level.

Test Plan:
- Reset, enable=1, defaults (div 50, dec 64):
  - pdm_clk period is 50 cycles, low 25 / high 25.
  - pdm_read_enable at cycles 49, 99, ...; integrator_enable 1 cycle later.
  - frame_start every 3200 cycles.
- Decimation 4, div 20:
  - comb_enable high for 20 cycles out of every 80.
  - Rising edge coincides with every 4th integrator_enable pulse.
- Config in RUN (div 20 -> 30, dec 4 -> 8):
  - cfg_ready drops for the remainder of the frame.
  - The new period appears only after the frame_start boundary, with no shortened pdm_clk phase.
- Illegal configs (cfg_pdm_div=10 at CHANNELS=8, and cfg_decimation=1):
  - cfg_err pulses; active settings unchanged; cfg_ready stays 1.
- enable dropped mid-period at div_cnt=7:
  - Next cycle all outputs are 0.
  - On re-enable, the first pdm_read_enable comes exactly pdm_div-1 cycles later.
- resetn asserted mid-frame with pending=1:
  - Outputs clear asynchronously; pending is dropped; defaults are restored after release.
